rx_pattern_chk: RTL and testbench
=================================

Name: rx_pattern_chk

Overview:
- Consumer stage directly downstream of the UART byte receiver (rx_inf) inside rx_top.
- Takes each received byte strobe (rx_vld/rx_data) and checks it against the test pattern selected by tx_pattern.
- Tracks lock state and exports a received-byte total, an error total and a lock flag for the board-test status path.
- rx_total of rx_top is driven from this block.

Parameters:
- LOSS_THR, 4: consecutive mismatching bytes in CHECK that force a return to HUNT (legal range 1..15).
- CNT_W, 32: width of rx_total and err_total.

Ports:
- clk_sys  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- rx_vld  input  1  one-cycle strobe from rx_inf; rx_data valid in that cycle.
- rx_data  input  8  received byte.
- tx_pattern  input  1  pattern select: 0 = incrementing byte (N, N+1, ... mod 256); 1 = alternating 0x55/0xAA.
- rx_total  output  CNT_W  count of all bytes accepted since reset.
- err_total  output  CNT_W  count of mismatching bytes checked in CHECK.
- rx_lock  output  1  high while in CHECK.
- err_pulse  output  1  one-cycle pulse, registered, for each counted mismatch.

Behaviour:
- All outputs reset asynchronously on rst high: rx_total=0, err_total=0, rx_lock=0, err_pulse=0. The FSM resets to HUNT, the expected-byte register to 0x00 and the miss counter to 0.
- The clock enable for all state is rx_vld. With rx_vld low, nothing changes except that err_pulse returns to 0.
- rx_total increments by 1 on every rx_vld, in any state. It saturates at all-ones and never wraps.
- FSM states:
  - HUNT: on rx_vld, seed expected with next(rx_data), where next(x) = x+1 mod 256 for pattern 0. For pattern 1, next(0x55)=0xAA and next(0xAA)=0x55.
    - Pattern 1 with a byte other than 0x55/0xAA: stay in HUNT, no seed, no error count.
    - Otherwise go to CHECK with miss=0. The seeding byte is never counted as an error.
  - CHECK, rx_data == expected: expected <= next(rx_data), miss <= 0.
  - CHECK, rx_data != expected:
    - err_total += 1 (saturating).
    - err_pulse = 1 on the following cycle.
    - expected <= next(expected); the count is kept on free-running expectation, not reseeded.
    - miss += 1. If miss reaches LOSS_THR, go to HUNT in that same update and clear rx_lock.
- rx_lock is registered: high the cycle after the HUNT→CHECK transition, low the cycle after the CHECK→HUNT transition.
- A tx_pattern change is detected by a registered copy differing from the input.
  - It forces HUNT and clears miss on the next cycle.
  - The counters are not cleared.
  - If rx_vld coincides with the change cycle, the byte is counted in rx_total only; it is neither checked nor used as a seed.
- Latency: rx_total, err_total and rx_lock reflect a byte one clk_sys cycle after its rx_vld.
- Back-to-back rx_vld on consecutive cycles must be supported, even though rx_inf cannot produce them.
- Reset asserted mid-operation: immediate clear of all state. The first byte after release is a HUNT seed.

Optional Feature:
- Macro RX_PATTERN_CHK_CLR_EN.
- Defined:
  - Adds input port cnt_clr (1 bit, synchronous, active-high).
  - While cnt_clr is high, rx_total and err_total are held at 0 and the FSM is forced to HUNT.
  - A byte arriving with cnt_clr high is dropped entirely.
- Undefined: no cnt_clr port; counters clear only on rst.

Test Plan:
- Pattern 0, send 0x10,0x11,...,0x4F (64 bytes) spaced by 10 clocks → rx_total=64, err_total=0, rx_lock=1 one cycle after the first byte.
- Pattern 0 locked at 0x20, send 0x21,0x99,0x23,0x24 → err_total=1, single err_pulse after 0x99, lock retained, later bytes match with no further errors.
- LOSS_THR=4, locked, send 4 bytes of 0x00 when 0x30.. is expected → err_total=4, rx_lock falls after the 4th. The next byte 0x50 reseeds, and 0x51 then checks clean.
- Pattern 1, send 0x12,0x55,0xAA,0x55 → the first byte is ignored in HUNT, lock on 0x55, err_total=0, rx_total=4.
- Toggle tx_pattern while locked, coincident with rx_vld → rx_total increments, no error, rx_lock drops next cycle.
- Force rx_total to 0xFFFFFFFE (or use CNT_W=4 and preload to 14), send 3 bytes → rx_total holds all-ones. Assert rst mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/rx_pattern_chk.sv
// rx_pattern_chk: checks received bytes against the selected test pattern, tracks lock and counts bytes/errors; define RX_PATTERN_CHK_CLR_EN to add the cnt_clr counter-clear port
module rx_pattern_chk #(
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk_sys,
  input  logic             rst,
`ifdef RX_PATTERN_CHK_CLR_EN
  input  logic             cnt_clr,
`endif
  input  logic             rx_vld,
  input  logic [7:0]       rx_data,
  input  logic             tx_pattern,
  output logic [CNT_W-1:0] rx_total,
  output logic [CNT_W-1:0] err_total,
  output logic             rx_lock,
  output logic             err_pulse
);
  typedef enum logic {HUNT, CHECK} state_t;
  localparam logic [3:0] THR = 4'(LOSS_THR);
  state_t     state, state_n;
  logic [7:0] expected, exp_n;
  logic [3:0] miss, miss_n;
  logic       pat_q, pat_chg, clr, tot_inc, err_inc, alt_byte;
`ifdef RX_PATTERN_CHK_CLR_EN
  assign clr = cnt_clr;
`else
  assign clr = 1'b0;
`endif
  function automatic logic [7:0] nxt(input logic pat, input logic [7:0] x);
    return pat ? ((x == 8'h55) ? 8'hAA : 8'h55) : x + 8'd1;
  endfunction
  assign pat_chg  = pat_q != tx_pattern;
  assign alt_byte = rx_data == 8'h55 || rx_data == 8'hAA;
  assign rx_lock  = state == CHECK;
  // pattern-select history; left out of reset so it already tracks the input when rst releases
  always_ff @(posedge clk_sys)
    pat_q <= tx_pattern;
  // state and counter registers, all advanced only by the decode below
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      expected  <= 8'h00;
      miss      <= 4'd0;
      rx_total  <= '0;
      err_total <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= exp_n;
      miss      <= miss_n;
      err_pulse <= err_inc;
      rx_total  <= clr ? '0 : rx_total + CNT_W'(tot_inc && rx_total != '1);
      err_total <= clr ? '0 : err_total + CNT_W'(err_inc && err_total != '1);
    end
  end
  // next-state decode: clear and pattern change override byte processing
  always_comb begin
    state_n = state;
    exp_n   = expected;
    miss_n  = miss;
    tot_inc = 1'b0;
    err_inc = 1'b0;
    if (clr || pat_chg) begin
      state_n = HUNT;
      miss_n  = 4'd0;
      tot_inc = !clr && rx_vld;
    end else if (rx_vld) begin
      tot_inc = 1'b1;
      if (state == HUNT) begin
        if (!tx_pattern || alt_byte) begin
          state_n = CHECK;
          exp_n   = nxt(tx_pattern, rx_data);
          miss_n  = 4'd0;
        end
      end else if (rx_data == expected) begin
        exp_n  = nxt(tx_pattern, rx_data);
        miss_n = 4'd0;
      end else begin
        err_inc = 1'b1;
        exp_n   = nxt(tx_pattern, expected);
        miss_n  = miss + 4'd1;
        state_n = (miss_n == THR) ? HUNT : CHECK;
      end
    end
  end
endmodule

// File: tb/tb_rx_pattern_chk.sv
// tb_rx_pattern_chk: directed self-checking bench for rx_pattern_chk, with a 4-bit-counter instance for saturation
module tb_rx_pattern_chk;
  logic        clk_sys = 1'b0;
  logic        rst, rx_vld, tx_pattern;
  logic [7:0]  rx_data;
  logic [31:0] rx_total, err_total;
  logic        rx_lock, err_pulse;
  logic [3:0]  sat_total, sat_err;
  logic        sat_lock, sat_pulse;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk_sys = ~clk_sys;
  rx_pattern_chk #(.LOSS_THR(4), .CNT_W(32)) u_dut (
    .clk_sys(clk_sys), .rst(rst),
`ifdef RX_PATTERN_CHK_CLR_EN
    .cnt_clr(1'b0),
`endif
    .rx_vld(rx_vld), .rx_data(rx_data), .tx_pattern(tx_pattern),
    .rx_total(rx_total), .err_total(err_total), .rx_lock(rx_lock), .err_pulse(err_pulse)
  );
  rx_pattern_chk #(.LOSS_THR(4), .CNT_W(4)) u_sat (
    .clk_sys(clk_sys), .rst(rst),
`ifdef RX_PATTERN_CHK_CLR_EN
    .cnt_clr(1'b0),
`endif
    .rx_vld(rx_vld), .rx_data(rx_data), .tx_pattern(tx_pattern),
    .rx_total(sat_total), .err_total(sat_err), .rx_lock(sat_lock), .err_pulse(sat_pulse)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk_sys);
    rx_vld  = 1'b1;
    rx_data = b;
    @(negedge clk_sys);
    rx_vld  = 1'b0;
  endtask
  task automatic state3(input string tag, input logic [31:0] tot, input logic [31:0] err, input logic lock);
    chk({tag, "_total"}, rx_total, tot);
    chk({tag, "_err"}, err_total, err);
    chk({tag, "_lock"}, 32'(rx_lock), 32'(lock));
  endtask
  initial begin
    logic [7:0] burst [4];
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; tx_pattern = 1'b0;
    repeat (3) @(negedge clk_sys);
    state3("reset", 0, 0, 1'b0);
    chk("reset_pulse", 32'(err_pulse), 0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send(8'h10 + 8'(i));
      if (i == 0) state3("first_seed", 1, 0, 1'b1);
      repeat (10) @(negedge clk_sys);
    end
    state3("inc64", 64, 0, 1'b1);
    chk("sat_total64", 32'(sat_total), 15);
    send(8'h50);
    send(8'hFF);
    chk("single_pulse", 32'(err_pulse), 1);
    state3("single_err", 66, 1, 1'b1);
    @(negedge clk_sys);
    chk("pulse_clear", 32'(err_pulse), 0);
    send(8'h52);
    send(8'h53);
    state3("after_err", 68, 1, 1'b1);
    chk("no_pulse_match", 32'(err_pulse), 0);
    for (int i = 0; i < 3; i++) send(8'h00);
    state3("miss3", 71, 4, 1'b1);
    send(8'h00);
    state3("loss", 72, 5, 1'b0);
    send(8'h50);
    state3("reseed", 73, 5, 1'b1);
    send(8'h51);
    state3("reseed_clean", 74, 5, 1'b1);
    chk("sat_err", 32'(sat_err), 5);
    @(negedge clk_sys);
    tx_pattern = 1'b1;
    rx_vld     = 1'b1;
    rx_data    = 8'h52;
    @(negedge clk_sys);
    rx_vld     = 1'b0;
    state3("pat_chg", 75, 5, 1'b0);
    send(8'h12);
    state3("alt_ignore", 76, 5, 1'b0);
    send(8'h55);
    state3("alt_lock", 77, 5, 1'b1);
    send(8'hAA);
    send(8'h55);
    state3("alt_clean", 79, 5, 1'b1);
    send(8'h55);
    chk("alt_pulse", 32'(err_pulse), 1);
    send(8'h55);
    state3("alt_freerun", 81, 6, 1'b1);
    burst = '{8'hAA, 8'h55, 8'h00, 8'h00};
    @(negedge clk_sys);
    foreach (burst[i]) begin
      rx_vld  = 1'b1;
      rx_data = burst[i];
      @(negedge clk_sys);
    end
    rx_vld = 1'b0;
    state3("b2b", 85, 8, 1'b1);
    chk("b2b_pulse", 32'(err_pulse), 1);
    chk("sat_hold", 32'(sat_total), 15);
    @(negedge clk_sys);
    rx_vld  = 1'b1;
    rx_data = 8'h55;
    #2 rst  = 1'b1;
    #1;
    state3("async_rst", 0, 0, 1'b0);
    chk("async_rst_pulse", 32'(err_pulse), 0);
    @(negedge clk_sys);
    rx_vld = 1'b0;
    @(negedge clk_sys);
    rst = 1'b0;
    send(8'h55);
    state3("post_rst_seed", 1, 0, 1'b1);
    chk("post_rst_sat", 32'(sat_total), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
